// File: rtl/control_pipeline.sv
// Carries decoded control bundles through ID/EX, EX/MEM and MEM/WB, detecting
// load-use stalls, resolving taken branches in MEM and counting retirements.
module control_pipeline #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   idValid,
  input  logic [3:0]             exControlIn,
  input  logic [2:0]             memControlIn,
  input  logic [1:0]             wbControlIn,
  input  logic [4:0]             idRs,
  input  logic [4:0]             idRt,
  input  logic [4:0]             idRd,
  input  logic                   aluZeroMem,
  output logic [3:0]             exControl,
  output logic [2:0]             memControl,
  output logic [1:0]             wbControl,
  output logic [4:0]             wbDest,
  output logic                   stall,
  output logic                   pcSrc,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Upstream contract: stall=1 means hold PC and IF/ID this cycle (ID/EX takes
  // a bubble); pcSrc=1 means load the branch target (ID/EX and EX/MEM squashed).
  // Both are combinational and settle before the next rising edge.

  // ID/EX
  logic [3:0] idex_ex;
  logic [2:0] idex_mem;
  logic [1:0] idex_wb;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;
  logic       idex_valid;

  // EX/MEM
  logic [2:0] exmem_mem;
  logic [1:0] exmem_wb;
  logic [4:0] exmem_dest;
  logic       exmem_valid;

  // MEM/WB
  logic [1:0] memwb_wb;
  logic [4:0] memwb_dest;
  logic       memwb_valid;

  logic [COUNT_WIDTH-1:0] retired_q;

  logic       branch_taken;
  logic       load_use;
  logic       rt_match;
  logic [4:0] ex_dest;

  always_comb begin
    branch_taken = exmem_valid & exmem_mem[2] & aluZeroMem;
    rt_match     = (idex_rt == idRs) | (idex_rt == idRt);
    // A flush removes the instruction in ID, so there is nothing left to stall.
    load_use     = idValid & idex_valid & idex_mem[1] & (idex_rt != 5'd0) &
                   rt_match & ~branch_taken;
    ex_dest      = idex_ex[3] ? idex_rd : idex_rt;
  end

  // ID/EX: bubble on either stall or flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_ex    <= 4'd0;
      idex_mem   <= 3'd0;
      idex_wb    <= 2'd0;
      idex_rt    <= 5'd0;
      idex_rd    <= 5'd0;
      idex_valid <= 1'b0;
    end else if (branch_taken || load_use) begin
      idex_ex    <= 4'd0;
      idex_mem   <= 3'd0;
      idex_wb    <= 2'd0;
      idex_rt    <= 5'd0;
      idex_rd    <= 5'd0;
      idex_valid <= 1'b0;
    end else begin
      idex_ex    <= exControlIn;
      idex_mem   <= memControlIn;
      idex_wb    <= wbControlIn;
      idex_rt    <= idRt;
      idex_rd    <= idRd;
      idex_valid <= idValid;
    end
  end

  // EX/MEM: bubble only on flush; a stalled lw still moves on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exmem_mem   <= 3'd0;
      exmem_wb    <= 2'd0;
      exmem_dest  <= 5'd0;
      exmem_valid <= 1'b0;
    end else if (branch_taken) begin
      exmem_mem   <= 3'd0;
      exmem_wb    <= 2'd0;
      exmem_dest  <= 5'd0;
      exmem_valid <= 1'b0;
    end else begin
      exmem_mem   <= idex_mem;
      exmem_wb    <= idex_wb;
      exmem_dest  <= ex_dest;
      exmem_valid <= idex_valid;
    end
  end

  // MEM/WB always advances, so a taken branch still retires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memwb_wb    <= 2'd0;
      memwb_dest  <= 5'd0;
      memwb_valid <= 1'b0;
    end else begin
      memwb_wb    <= exmem_wb;
      memwb_dest  <= exmem_dest;
      memwb_valid <= exmem_valid;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (memwb_valid) begin
      retired_q <= retired_q + COUNT_ONE;
    end
  end

  assign exControl    = idex_ex;
  assign memControl   = exmem_mem;
  assign wbControl    = memwb_wb;
  assign wbDest       = memwb_dest;
  assign stall        = load_use;
  assign pcSrc        = branch_taken;
  assign retiredCount = retired_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Randomized bench for control_pipeline: instructions are tracked as records
// moving through three slots and compared each cycle with the DUT.
module tb_control_pipeline;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          idValid = 1'b0;
  logic [3:0]    exControlIn = '0;
  logic [2:0]    memControlIn = '0;
  logic [1:0]    wbControlIn = '0;
  logic [4:0]    idRs = '0, idRt = '0, idRd = '0;
  logic          aluZeroMem = 1'b0;
  logic [3:0]    exControl;
  logic [2:0]    memControl;
  logic [1:0]    wbControl;
  logic [4:0]    wbDest;
  logic          stall, pcSrc;
  logic [CW-1:0] retiredCount;

  control_pipeline #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .idValid(idValid),
    .exControlIn(exControlIn), .memControlIn(memControlIn), .wbControlIn(wbControlIn),
    .idRs(idRs), .idRt(idRt), .idRd(idRd), .aluZeroMem(aluZeroMem),
    .exControl(exControl), .memControl(memControl), .wbControl(wbControl),
    .wbDest(wbDest), .stall(stall), .pcSrc(pcSrc), .retiredCount(retiredCount)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       valid;
  } instr_t;

  instr_t bubble = '{ex: 4'd0, mem: 3'd0, wb: 2'd0, rt: 5'd0, rd: 5'd0, valid: 1'b0};
  instr_t m_ex, m_mem, m_wb;   // instruction occupying ID/EX, EX/MEM, MEM/WB
  int     m_count;

  function automatic logic [4:0] dest_of(input instr_t i);
    return i.ex[3] ? i.rd : i.rt;
  endfunction

  task automatic model_reset();
    m_ex = bubble; m_mem = bubble; m_wb = bubble; m_count = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("exControl",    32'(exControl),    32'(m_ex.ex));
    check("memControl",   32'(memControl),   32'(m_mem.mem));
    check("wbControl",    32'(wbControl),    32'(m_wb.wb));
    check("wbDest",       32'(wbDest),       32'(dest_of(m_wb)));
    check("retiredCount", 32'(retiredCount), 32'(m_count));
  endtask

  // One cycle: called at a negedge, drives ID, checks stall/pcSrc, steps the
  // model on the rising edge and checks registered outputs at the next negedge.
  task automatic cycle(input logic v, input logic [3:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z,
                       output logic s_obs, output logic p_obs);
    logic   pc_m, stall_m;
    instr_t nw;
    idValid = v; exControlIn = ex; memControlIn = mem; wbControlIn = wb;
    idRs = rs; idRt = rt; idRd = rd; aluZeroMem = z;
    #1;
    pc_m    = m_mem.valid && m_mem.mem[2] && z;
    stall_m = !pc_m && v && m_ex.valid && m_ex.mem[1] && (m_ex.rt != 0) &&
              (m_ex.rt == rs || m_ex.rt == rt);
    s_obs = stall; p_obs = pcSrc;
    check("stall", 32'(stall), 32'(stall_m));
    check("pcSrc", 32'(pcSrc), 32'(pc_m));
    @(posedge clock);
    nw = '{ex: ex, mem: mem, wb: wb, rt: rt, rd: rd, valid: v};
    if (m_wb.valid) m_count = (m_count + 1) % (1 << CW);
    m_wb  = m_mem;
    m_mem = pc_m ? bubble : m_ex;
    m_ex  = (pc_m || stall_m) ? bubble : nw;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic s, p;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, s, p);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("stall_rst", 32'(stall), 32'd0);
    check("pcSrc_rst", 32'(pcSrc), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic s, p;
  logic [3:0] r_ex;
  logic [2:0] r_mem;
  logic [1:0] r_wb;
  logic [4:0] r_rs, r_rt, r_rd;
  logic       r_v;

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_outputs();

    // R-type latency through the stages.
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd8, 1'b0, s, p);
    check("rtype_ex", 32'(exControl), 32'hC);
    idle(1);
    check("rtype_mem", 32'(memControl), 32'h0);
    idle(1);
    check("rtype_wb", 32'(wbControl), 32'h2);
    check("rtype_dest", 32'(wbDest), 32'd8);
    idle(1);
    check("rtype_retired", 32'(retiredCount), 32'd1);

    // Load-use: lw $9 then consumer of $9; upstream holds ID for one cycle.
    cycle(1'b1, 4'b0011, 3'b010, 2'b11, 5'd0, 5'd9, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd9, 5'd3, 5'd4, 1'b0, s, p);
    check("lu_stall", 32'(s), 32'd1);
    check("lu_bubble", 32'(exControl), 32'h0);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd9, 5'd3, 5'd4, 1'b0, s, p);
    check("lu_stall_once", 32'(s), 32'd0);
    idle(3);
    // lw to $0 never stalls.
    cycle(1'b1, 4'b0011, 3'b010, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd4, 1'b0, s, p);
    check("lu_r0", 32'(s), 32'd0);
    idle(3);

    // Taken beq squashes two younger instructions and still retires.
    cycle(1'b1, 4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd5, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd6, 1'b1, s, p);
    check("br_pcsrc", 32'(p), 32'd1);
    check("br_ex", 32'(exControl), 32'h0);
    check("br_mem", 32'(memControl), 32'h0);
    check("br_wb", 32'(wbControl), 32'h0);
    idle(3);
    // Not taken: no squash.
    cycle(1'b1, 4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd5, 1'b0, s, p);
    cycle(1'b1, 4'b1000, 3'b000, 2'b10, 5'd1, 5'd2, 5'd6, 1'b0, s, p);
    check("nt_pcsrc", 32'(p), 32'd0);
    check("nt_ex", 32'(exControl), 32'h8);
    idle(3);

    // Flush beats stall: beq in EX/MEM, lw $5 in ID/EX, consumer of $5 in ID.
    cycle(1'b1, 4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b0011, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0, s, p);
    cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd5, 5'd1, 5'd7, 1'b1, s, p);
    check("fb_pcsrc", 32'(p), 32'd1);
    check("fb_stall", 32'(s), 32'd0);
    check("fb_ex", 32'(exControl), 32'h0);
    check("fb_mem", 32'(memControl), 32'h0);
    idle(3);

    // Counter wrap with COUNT_WIDTH=4.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'(i), 1'b0, s, p);
      if (i == 19) check("wrap_zero", 32'(retiredCount), 32'd0);
      if (i == 20) check("wrap_one", 32'(retiredCount), 32'd1);
    end
    idle(3);

    // Randomized traffic; upstream holds ID while stalled.
    r_v = 1'b0; r_ex = '0; r_mem = '0; r_wb = '0; r_rs = '0; r_rt = '0; r_rd = '0; s = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!s) begin
        case ($urandom_range(0, 4))
          0: begin r_ex = 4'b1100; r_mem = 3'b000; r_wb = 2'b10; end
          1: begin r_ex = 4'b0011; r_mem = 3'b010; r_wb = 2'b11; end
          2: begin r_ex = 4'b0001; r_mem = 3'b001; r_wb = 2'b00; end
          3: begin r_ex = 4'b0010; r_mem = 3'b100; r_wb = 2'b00; end
          default: begin
            r_ex = 4'($urandom); r_mem = 3'($urandom); r_wb = 2'($urandom);
          end
        endcase
        r_v  = ($urandom_range(0, 3) != 0);
        r_rs = 5'($urandom_range(0, 3));
        r_rt = 5'($urandom_range(0, 3));
        r_rd = 5'($urandom_range(0, 31));
      end
      cycle(r_v, r_ex, r_mem, r_wb, r_rs, r_rt, r_rd, 1'($urandom_range(0, 1)), s, p);
    end

    // Asynchronous reset with a full pipeline.
    idValid = 1'b1; exControlIn = 4'b1100; memControlIn = 3'b010; wbControlIn = 2'b11;
    idRs = 5'd1; idRt = 5'd1; idRd = 5'd3;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_ex", 32'(exControl), 32'h0);
    check("rst_mem", 32'(memControl), 32'h0);
    check("rst_wb", 32'(wbControl), 32'h0);
    check("rst_dest", 32'(wbDest), 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pcsrc", 32'(pcSrc), 32'd0);
    check("rst_count", 32'(retiredCount), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_ex", 32'(exControl), 32'h0);
    check("post_rst_wb", 32'(wbControl), 32'h0);
    check("post_rst_count", 32'(retiredCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
